// File: rtl/ex2_pipe_block_pkg.sv
// Shared definitions for the ex2 pipelined logic block: op encodings and
// the occupancy-count width derivation.
package ex2_pipe_block_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_XNOR = 2'd3
  } op_e;

  // Count must represent 0..depth inclusive.
  function automatic int cw_of(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ex2_pipe_block_if.sv
// Handshake/data bundle between the stimulus source, the ex2 pipeline and
// the downstream consumer.
interface ex2_pipe_block_if #(
  parameter int W     = 4,
  parameter int DEPTH = 3
);
  import ex2_pipe_block_pkg::*;

  localparam int CW = cw_of(DEPTH);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [1:0]    op;
  logic [W-1:0]  C;
  logic          c_valid;
  logic [W-1:0]  D;
  logic          d_valid;
  logic          d_ready;
  logic [CW-1:0] count;

  modport slave (
    input  in_valid, A, B, op, d_ready,
    output in_ready, C, c_valid, D, d_valid, count
  );

  modport master (
    output in_valid, A, B, op, d_ready,
    input  in_ready, C, c_valid, D, d_valid, count
  );

endinterface

// File: rtl/ex2_pipe_stage.sv
// One pipeline register {valid, data} with synchronous reset and load enable.
module ex2_pipe_stage #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: state uses non-blocking assignments so every stage samples its
  // upstream neighbour's pre-edge value; data is cleared with valid so a
  // reset leaves no stale payload visible on C or D.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex2_pipe_block.sv
// W-bit two-operand bitwise logic pipeline: early tap C from stage 1, final
// result D from stage DEPTH, global stall driven by the consumer.
module ex2_pipe_block
  import ex2_pipe_block_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 3
) (
  input logic           clk,
  input logic           rst,
  ex2_pipe_block_if.slave bus
);

  localparam int CW = cw_of(DEPTH);

  logic          advance;
  logic          accept;
  logic          emit;
  logic [W-1:0]  result;
  logic [CW-1:0] count_q;
  logic [W:0]    stage_d [DEPTH];
  logic [W:0]    stage_q [DEPTH];

  // NOTE: every path of a combinational block assigns a default first so no
  // latch is inferred for an unmatched selector value.
  always_comb begin
    result = '0;
    unique case (op_e'(bus.op))
      OP_AND:  result = bus.A & bus.B;
      OP_OR:   result = bus.A | bus.B;
      OP_XOR:  result = bus.A ^ bus.B;
      OP_XNOR: result = ~(bus.A ^ bus.B);
    endcase
  end

  // A bubble in the last stage can always be overwritten, so the whole pipe
  // moves whenever the output slot is empty or being consumed.
  assign advance = ~bus.d_valid | bus.d_ready;
  assign accept  = bus.in_valid & advance;
  assign emit    = bus.d_valid & bus.d_ready;

  assign stage_d[0] = {bus.in_valid, result};

  for (genvar k = 1; k < DEPTH; k++) begin : g_link
    assign stage_d[k] = stage_q[k-1];
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    ex2_pipe_stage #(
      .WIDTH (W + 1)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .en  (advance),
      .d   (stage_d[k]),
      .q   (stage_q[k])
    );
  end

  // Guards keep the counter within 0..DEPTH even if the handshake were
  // ever violated upstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (accept && !emit && count_q != CW'(DEPTH)) begin
      count_q <= count_q + CW'(1);
    end else if (!accept && emit && count_q != '0) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign bus.in_ready = advance;
  assign bus.C        = stage_q[0][W-1:0];
  assign bus.c_valid  = stage_q[0][W];
  assign bus.D        = stage_q[DEPTH-1][W-1:0];
  assign bus.d_valid  = stage_q[DEPTH-1][W];
  assign bus.count    = count_q;

endmodule

// File: doc/ex2_pipe_block.md
Name: ex2_pipe_block

Overview:
Parametrised successor to the single-bit two-input registered logic block. Takes W-bit operands A and B with a per-transaction operation select, and produces two registered results. C is the early result after 1 cycle. D is the late result after DEPTH cycles. The pipeline has a valid/ready handshake with global stall and an occupancy counter, and sits between a lab stimulus source and a downstream consumer.

Parameters:
W, 4, operand/result width in bits (>=1)
DEPTH, 3, number of pipeline stages from input to D (>=2); C is taken from stage 1
CW, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  A/B/op presented this cycle
in_ready  output  1  block accepts input this cycle
A  input  W  operand A
B  input  W  operand B
op  input  2  operation: 0=AND, 1=OR, 2=XOR, 3=XNOR (bitwise)
C  output  W  stage-1 result (early tap)
c_valid  output  1  stage 1 holds a valid transaction
D  output  W  stage-DEPTH result (final)
d_valid  output  1  final stage holds a valid transaction
d_ready  input  1  consumer takes D this cycle
count  output  CW  number of valid transactions currently in stages 1..DEPTH

Behaviour:
- Reset: when rst=1 at a rising edge, all stage valid bits clear, all stage data clear to 0, and count=0. After reset: C=0, D=0, c_valid=0, d_valid=0. A reset mid-operation discards all in-flight transactions; no partial output is produced.
- Operation: the result is computed combinationally from A, B and op at the input and registered into stage 1. The op value is bound to the transaction at acceptance; later op changes do not affect in-flight data.
- Advance: advance = ~d_valid | d_ready. in_ready = advance (combinational, not registered). When advance=1, every stage k+1 loads stage k (data and valid), and stage 1 loads {result, in_valid}. When advance=0, all stages hold, including bubbles.
- Acceptance: a transfer occurs when in_valid & in_ready. An input with in_ready=0 is not captured; the source must hold it.
- Output: a D transfer occurs when d_valid & d_ready. D and d_valid are stable while d_valid=1 and d_ready=0.
- Latency: with no stall, an input accepted at edge n appears on C/c_valid after edge n and on D/d_valid after edge n+DEPTH-1. C therefore leads D by DEPTH-1 cycles for the same transaction.
- C/c_valid: reflect stage 1 only. They are informational and have no handshake; they hold during a stall.
- Count, per edge:
  - incremented on accept without output
  - decremented on output without accept
  - unchanged on simultaneous accept and output, or on neither
  - range 0..DEPTH, and never wraps
- Full pipeline with d_ready=0: in_ready=0, count=DEPTH, and all outputs hold.
- Empty pipeline: d_valid=0, so advance=1 and in_ready=1 regardless of d_ready.
- Bubbles are not squeezed out; a gap in the input stream travels through as a gap.
- Width rules: all ops are bitwise over W bits with no carries. A and B are exactly W bits.

Decomposition:
- Shared package/header holds the op encodings (OP_AND=2'd0, OP_OR=2'd1, OP_XOR=2'd2, OP_XNOR=2'd3) and the CW derivation macro.
- One sub-module is natural: ex2_pipe_stage, a single W+1-bit register with sync reset and enable. It is instantiated DEPTH times via generate and driven by the shared advance signal.
- The op decoder and count logic live in the top.

Test Plan:
1. Reset and AND latency (W=4, DEPTH=3): assert rst for 1 cycle, then send one beat A=4'b1100, B=4'b1010, op=0 with d_ready=1 -> C=4'b1000 and c_valid=1 one cycle later; D=4'b1000 and d_valid=1 three cycles after acceptance; C returns to c_valid=0 next cycle.
2. All ops back-to-back with d_ready=1: A=4'b0110, B=4'b0011, op=0..3 on consecutive cycles -> D stream 0010, 0111, 0101, 1010 on 4 consecutive cycles. in_ready stays 1 and count peaks at 3.
3. Backpressure fill: d_ready=0 with a continuous in_valid stream -> exactly 3 beats accepted, then in_ready=0, count=3, D frozen at the first beat. Raise d_ready -> beats drain in order with no loss or duplication.
4. Simultaneous accept and output at full: count=3, then d_ready=1 and in_valid=1 -> count stays 3, and the new beat enters while the oldest exits.
5. Bubble preservation: send beat, idle cycle, beat with d_ready=1 -> d_valid pattern 1,0,1 at the output.
6. Reset mid-stream: count=2 in flight, then assert rst for 1 cycle -> next cycle c_valid=0, d_valid=0, count=0, C=D=0. No ghost beats after rst is released.
